// File: rtl/synth_pkg.sv
// synth_pkg: shared defaults and enums for the polyphonic voice allocator.
//   NUM_VOICES_DEF / NOTE_W_DEF : default voice count and note-number width
//   state_e    : allocator sequencing state
//   sel_case_e : which selection rule picked the target voice
package synth_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int NOTE_W_DEF     = 7;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RETRIG_LOW  = 2'd1,
        RETRIG_HIGH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_RETRIG = 2'd0,  // gated voice already playing this note
        SEL_FREE   = 2'd1,  // lowest-index voice, gate off and envelope finished
        SEL_AGED   = 2'd2,  // oldest voice with gate off (envelope still releasing)
        SEL_STEAL  = 2'd3   // everything gated: take the oldest voice
    } sel_case_e;

endpackage

// File: rtl/voice_select.sv
// voice_select: combinational target picker for a note-on.
//   gate_i/running_i : per-voice gate and envelope-active flags
//   note_i           : per-voice assigned note
//   rank_i           : per-voice age rank (greatest = oldest, all distinct)
//   note_num_i       : incoming note number
//   tgt_o/case_o     : chosen voice index and the rule that chose it
module voice_select
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int NOTE_W     = NOTE_W_DEF,
    localparam int AW        = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]             gate_i,
    input  logic [NUM_VOICES-1:0]             running_i,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_i,
    input  logic [NUM_VOICES-1:0][AW-1:0]     rank_i,
    input  logic [NOTE_W-1:0]                 note_num_i,
    output logic [AW-1:0]                     tgt_o,
    output sel_case_e                         case_o
);

    logic          hit, free, aged;
    logic [AW-1:0] hit_idx, free_idx, aged_idx, aged_rank, old_idx, old_rank;

    always_comb begin
        hit = 1'b0;  hit_idx  = '0;
        free = 1'b0; free_idx = '0;
        aged = 1'b0; aged_idx = '0; aged_rank = '0;
        old_idx = '0; old_rank = '0;
        // Scan downwards so the last match written is the lowest index.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_i[v] && note_i[v] == note_num_i) begin
                hit = 1'b1; hit_idx = AW'(v);
            end
            if (!gate_i[v] && !running_i[v]) begin
                free = 1'b1; free_idx = AW'(v);
            end
        end
        // Ranks are distinct, so greatest-rank searches have a unique winner.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!gate_i[v] && (!aged || rank_i[v] > aged_rank)) begin
                aged = 1'b1; aged_idx = AW'(v); aged_rank = rank_i[v];
            end
            if (rank_i[v] >= old_rank) begin
                old_idx = AW'(v); old_rank = rank_i[v];
            end
        end
    end

    always_comb begin
        if (hit) begin
            tgt_o = hit_idx;  case_o = SEL_RETRIG;
        end else if (free) begin
            tgt_o = free_idx; case_o = SEL_FREE;
        end else if (aged) begin
            tgt_o = aged_idx; case_o = SEL_AGED;
        end else begin
            tgt_o = old_idx;  case_o = SEL_STEAL;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to envelope voices with LRU stealing.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   note_valid_i/ready : event handshake (ready is combinational)
//   note_on_i, note_num_i : event type and note number
//   panic_i            : drop every gate, abandon any retrigger
//   running_i          : per-voice envelope-active flags (read only)
//   gate_o, voice_note_o : per-voice gate and assigned note (voice v at [v*NOTE_W +: NOTE_W])
//   stealing_o         : high during the forced gate-low/gate-high retrigger sequence
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int NOTE_W     = NOTE_W_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         note_valid_i,
    output logic                         note_ready_o,
    input  logic                         note_on_i,
    input  logic [NOTE_W-1:0]            note_num_i,
    input  logic                         panic_i,
    input  logic [NUM_VOICES-1:0]        running_i,
    output logic [NUM_VOICES-1:0]        gate_o,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note_o,
    output logic                         stealing_o
);

    localparam int AW = $clog2(NUM_VOICES);

    state_e                           state_q, state_d;
    logic [NUM_VOICES-1:0]            gate_q, gate_d;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0][AW-1:0]    rank_q, rank_d;
    logic [AW-1:0]                    tgt_q, tgt_d, sel_tgt;
    sel_case_e                        sel_case;
    logic                             stealing_q, stealing_d;
    logic                             accept, seq_needed;

    voice_select #(.NUM_VOICES(NUM_VOICES), .NOTE_W(NOTE_W)) u_sel (
        .gate_i     (gate_q),
        .running_i  (running_i),
        .note_i     (note_q),
        .rank_i     (rank_q),
        .note_num_i (note_num_i),
        .tgt_o      (sel_tgt),
        .case_o     (sel_case)
    );

    assign accept     = note_valid_i && note_ready_o;
    // Retrigger and steal both need a guaranteed low gate cycle.
    assign seq_needed = (sel_case == SEL_RETRIG) || (sel_case == SEL_STEAL);

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (panic_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:        if (accept && note_on_i && seq_needed) state_d = RETRIG_LOW;
                RETRIG_LOW:  state_d = RETRIG_HIGH;
                RETRIG_HIGH: state_d = IDLE;
                default:     state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        note_ready_o = rst_ni && (state_q == IDLE) && !panic_i;
        stealing_d   = (state_d != IDLE);
    end

    // Voice datapath next state
    always_comb begin
        gate_d = gate_q;
        note_d = note_q;
        rank_d = rank_q;
        tgt_d  = tgt_q;
        if (panic_i) begin
            gate_d = '0;
        end else if (state_q == RETRIG_LOW) begin
            gate_d[tgt_q] = 1'b1;
        end else if (accept) begin
            if (note_on_i) begin
                note_d[sel_tgt] = note_num_i;
                gate_d[sel_tgt] = !seq_needed;
                tgt_d           = sel_tgt;
                // Target becomes newest; everything newer than it ages by one.
                for (int v = 0; v < NUM_VOICES; v++)
                    if (rank_q[v] < rank_q[sel_tgt]) rank_d[v] = rank_q[v] + AW'(1);
                rank_d[sel_tgt] = '0;
            end else begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (gate_q[v] && note_q[v] == note_num_i) gate_d[v] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gate_q     <= '0;
            note_q     <= '0;
            tgt_q      <= '0;
            stealing_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= AW'(v);
        end else begin
            gate_q     <= gate_d;
            note_q     <= note_d;
            rank_q     <= rank_d;
            tgt_q      <= tgt_d;
            stealing_q <= stealing_d;
        end
    end

    assign gate_o       = gate_q;
    assign voice_note_o = note_q;
    assign stealing_o   = stealing_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NW = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              note_valid, note_on, panic;
    logic [NW-1:0]     note_num;
    logic [NV-1:0]     running;
    logic              note_ready_o, stealing_o;
    logic [NV-1:0]     gate_o;
    logic [NV*NW-1:0]  voice_note_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .note_valid_i (note_valid),
        .note_ready_o (note_ready_o),
        .note_on_i    (note_on),
        .note_num_i   (note_num),
        .panic_i      (panic),
        .running_i    (running),
        .gate_o       (gate_o),
        .voice_note_o (voice_note_o),
        .stealing_o   (stealing_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // lru[0] = most recently assigned voice, lru[$] = oldest.
    logic [NV-1:0]  gate_m;
    logic [NW-1:0]  note_m [NV];
    int             lru[$];
    int             busy;      // remaining cycles of retrigger sequence (2: gate low, 1: gate high)
    int             tgt_m;
    int             t;
    bit             seq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_m = '0;
            busy = 0; tgt_m = 0;
            lru.delete();
            for (int v = 0; v < NV; v++) begin
                note_m[v] = '0;
                lru.push_back(v);
            end
        end else if (panic) begin
            gate_m = '0;
            busy = 0;
        end else if (busy == 2) begin
            gate_m[tgt_m] = 1'b1;
            busy = 1;
        end else if (busy == 1) begin
            busy = 0;
        end else if (note_valid) begin
            if (note_on) begin
                t = -1; seq = 1'b0;
                for (int v = 0; v < NV && t < 0; v++)
                    if (gate_m[v] && note_m[v] == note_num) begin t = v; seq = 1'b1; end
                for (int v = 0; v < NV && t < 0; v++)
                    if (!gate_m[v] && !running[v]) t = v;
                for (int i = lru.size() - 1; i >= 0 && t < 0; i--)
                    if (!gate_m[lru[i]]) t = lru[i];
                if (t < 0) begin t = lru[lru.size() - 1]; seq = 1'b1; end
                note_m[t] = note_num;
                for (int i = 0; i < lru.size(); i++)
                    if (lru[i] == t) begin lru.delete(i); break; end
                lru.push_front(t);
                tgt_m = t;
                if (seq) begin gate_m[t] = 1'b0; busy = 2; end
                else gate_m[t] = 1'b1;
            end else begin
                for (int v = 0; v < NV; v++)
                    if (gate_m[v] && note_m[v] == note_num) gate_m[v] = 1'b0;
            end
        end
    end

    logic [NV*NW-1:0] exp_notes;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int v = 0; v < NV; v++) exp_notes[v*NW +: NW] = note_m[v];
            chk("model_gate", gate_o, gate_m);
            chk("model_notes", voice_note_o, exp_notes);
            chk("model_stealing", stealing_o, busy != 0);
            chk("model_ready", note_ready_o, rst_n && busy == 0 && !panic);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offer an event, hold it until accepted, return 1 time unit after the accepting edge.
    task automatic send(input logic on, input logic [NW-1:0] num);
        int n = 0;
        note_valid = 1'b1; note_on = on; note_num = num;
        #1;
        while (!note_ready_o && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout: note %0d not accepted within 20 cycles", num);
        end
        step();
        note_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; note_valid = 1'b0; note_on = 1'b0; note_num = '0;
        panic = 1'b0; running = '0;
        step(); step();
        mon_en = 1'b1;
        chk("rst_gate", gate_o, 0);
        chk("rst_ready", note_ready_o, 0);
        chk("rst_stealing", stealing_o, 0);
        chk("rst_notes", voice_note_o, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        step();

        // First note-on lands on voice 0 one cycle after handshake
        send(1'b1, 7'd60);
        chk("first_gate", gate_o, 4'b0001);
        chk("first_note0", voice_note_o[NW-1:0], 60);
        chk("first_ready", note_ready_o, 1);

        // Fill remaining voices, then steal the oldest (voice 0)
        running = 4'b0001; send(1'b1, 7'd62);
        running = 4'b0011; send(1'b1, 7'd64);
        running = 4'b0111; send(1'b1, 7'd65);
        running = 4'b1111;
        chk("full_gate", gate_o, 4'b1111);
        send(1'b1, 7'd67);
        chk("steal_low_gate", gate_o, 4'b1110);
        chk("steal_note0", voice_note_o[NW-1:0], 67);
        chk("steal_low_stealing", stealing_o, 1);
        chk("steal_low_ready", note_ready_o, 0);
        step();
        chk("steal_high_gate", gate_o, 4'b1111);
        chk("steal_high_stealing", stealing_o, 1);
        chk("steal_high_ready", note_ready_o, 0);
        step();
        chk("steal_done_stealing", stealing_o, 0);
        chk("steal_done_ready", note_ready_o, 1);

        // Same note again retriggers voice 0 only
        send(1'b1, 7'd67);
        chk("retrig_low_gate", gate_o, 4'b1110);
        step(); step();
        chk("retrig_high_gate", gate_o, 4'b1111);

        // Panic beats a simultaneous event
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd90; panic = 1'b1;
        #1 chk("panic_ready", note_ready_o, 0);
        step();
        note_valid = 1'b0; panic = 1'b0;
        chk("panic_gate", gate_o, 4'b0000);
        chk("panic_notes_kept", voice_note_o, {7'd65, 7'd64, 7'd62, 7'd67});

        // Fresh start: released voice still running is skipped for a free one
        rst_n = 1'b0; step();
        @(negedge clk); #1 rst_n = 1'b1;
        step();
        running = '0;
        send(1'b1, 7'd60);
        send(1'b0, 7'd60);
        chk("noteoff_gate", gate_o, 4'b0000);
        running = 4'b0001;
        send(1'b1, 7'd62);
        chk("free_gate", gate_o, 4'b0010);
        chk("free_notes", voice_note_o, {7'd0, 7'd0, 7'd62, 7'd60});

        // All running: oldest gate-off voice (3), then 2, then 0, then steal 1
        running = 4'b1111;
        send(1'b1, 7'd70);
        chk("aged_gate", gate_o, 4'b1010);
        send(1'b1, 7'd71);
        send(1'b1, 7'd72);
        chk("aged_full_gate", gate_o, 4'b1111);
        send(1'b1, 7'd73);
        chk("steal1_gate", gate_o, 4'b1101);

        // Panic during RETRIG_LOW with an event pending
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd74; panic = 1'b1;
        #1 chk("pend_ready_panic", note_ready_o, 0);
        step();
        chk("pend_gate_panic", gate_o, 4'b0000);
        chk("pend_stealing_panic", stealing_o, 0);
        panic = 1'b0;
        #1 chk("pend_ready_after", note_ready_o, 1);
        step();
        note_valid = 1'b0;
        chk("pend_gate", gate_o, 4'b1000);
        chk("pend_note3", voice_note_o[3*NW +: NW], 74);

        // Async reset while in RETRIG_HIGH
        send(1'b1, 7'd74);
        step();
        chk("rh_stealing", stealing_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gate", gate_o, 0);
        chk("async_notes", voice_note_o, 0);
        chk("async_stealing", stealing_o, 0);
        chk("async_ready", note_ready_o, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        step();
        running = '0;
        send(1'b1, 7'd80);
        chk("post_rst_gate", gate_o, 4'b0001);
        chk("post_rst_notes", voice_note_o, {7'd0, 7'd0, 7'd0, 7'd80});

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of envelope voices managed (power of two, 2..16).
REQ-002 Parameter NOTE_W, default 7, note-number width.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 NoteValid  input  1  note event offered this cycle.
REQ-006 NoteReady  output  1  allocator accepts event; transfer when NoteValid && NoteReady.
REQ-007 NoteOn  input  1  1 = note-on, 0 = note-off; qualified by NoteValid.
REQ-008 NoteNum  input  NOTE_W  note number of event.
REQ-009 Panic  input  1  drop all gates.
REQ-010 Running  input  NUM_VOICES  per-voice envelope-active flag from each envelope generator.
REQ-011 Gate  output  NUM_VOICES  per-voice gate to each envelope generator.
REQ-012 VoiceNote  output  NUM_VOICES*NOTE_W  note assigned to voice v at bits [v*NOTE_W +: NOTE_W].
REQ-013 Stealing  output  1  high while a steal/retrigger sequence is in progress.

Function
REQ-014 FSM states: IDLE, RETRIG_LOW, RETRIG_HIGH; NoteReady = (state==IDLE) && !Panic.
REQ-015 Note-on in IDLE, target selection priority: (a) voice with Gate=1 and VoiceNote==NoteNum (retrigger); (b) lowest-index voice with Gate=0 and Running=0; (c) voice with Gate=0 and greatest age; (d) voice with Gate=1 and greatest age (steal).
REQ-016 Cases (b)/(c): VoiceNote and Gate=1 written on the cycle after the handshake; FSM stays IDLE.
REQ-017 Cases (a)/(d): next cycle VoiceNote written, Gate of target forced 0, FSM -> RETRIG_LOW; following cycle Gate=1, FSM -> RETRIG_HIGH; next cycle -> IDLE (guaranteed one-cycle gate low for envelope retrigger).
REQ-018 Stealing = 1 in RETRIG_LOW and RETRIG_HIGH, else 0.
REQ-019 Note-off in IDLE: every voice with Gate=1 and VoiceNote==NoteNum gets Gate=0 next cycle; VoiceNote retained; no match -> event consumed, no effect.
REQ-020 Age: per-voice $clog2(NUM_VOICES)-bit rank, all ranks distinct; on any note-on assignment target rank -> 0, every voice with rank below target's old rank increments; greatest rank = oldest.
REQ-021 Age ties impossible by construction; reset ranks are voice index v (voice NUM_VOICES-1 oldest).
REQ-022 Panic: next cycle all Gate = 0, FSM -> IDLE, any in-flight steal abandoned; ranks and VoiceNote unchanged.
REQ-023 Panic and NoteValid in the same cycle: Panic wins, event not accepted (NoteReady=0).
REQ-024 Running is sampled only for selection; allocator never drives or alters Running.
REQ-025 Event with NoteValid=1 held while NoteReady=0 SHALL be accepted unchanged once NoteReady returns to 1.

Reset
REQ-026 Reset=0 asynchronously sets: Gate=0, VoiceNote=0, FSM=IDLE, Stealing=0, ranks per REQ-021; NoteReady=0 while Reset=0.
REQ-027 Reset asserted mid-steal aborts sequence; first accepted event after release follows REQ-015 from reset state.

Structure
REQ-028 Shared package synth_pkg holds NUM_VOICES/NOTE_W defaults and the FSM state enum (IDLE, RETRIG_LOW, RETRIG_HIGH).
REQ-029 One sub-module voice_select: combinational, takes Gate, Running, VoiceNote, ranks, NoteNum; returns target index and case (a-d).
REQ-030 All outputs registered except NoteReady.

Verification
REQ-031 Reset release, note-on 60 -> 1 cycle later Gate=4'b0001, VoiceNote[0]=60, NoteReady stays 1.
REQ-032 Note-ons 60,62,64,65 then 67, all Running=1 -> voice 0 (oldest) Gate 0 for one cycle then 1, VoiceNote[0]=67, Stealing high 2 cycles, NoteReady low 2 cycles.
REQ-033 Note-on 60, note-off 60 with Running[0]=1, note-on 62 -> 62 to voice 1 (free, Running=0), voice 0 untouched.
REQ-034 Note-on 60 twice -> same voice retriggered (gate 1-0-1), no other voice gated.
REQ-035 Panic during RETRIG_LOW with NoteValid high -> next cycle Gate=0, FSM IDLE, pending event accepted the cycle after Panic deasserts.
REQ-036 Reset=0 asserted in RETRIG_HIGH -> Gate=0 and VoiceNote=0 immediately, without a clock edge.
